layer_mac_scheduler: RTL and testbench
======================================

# layer_mac_scheduler

Time-multiplexed layer engine for the fixed-point ECG classifier. It accepts one input activation vector and evaluates all N_OUT neurons of a fully connected layer on a single shared multiply-accumulate unit, one neuron at a time. Weights and biases are fetched from external synchronous ROMs. It emits one ReLU'd Q13 result per neuron over a valid/ready handshake. It replaces per-neuron parallel nodes where area matters more than throughput.

## Interface
- N_IN, 15, inputs per neuron
- N_OUT, 32, neurons in the layer
- DW, 32, data/weight/bias width
- FRAC, 13, fractional bits of the fixed-point format
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; all state cleared immediately
- in_valid  in  1  input vector valid
- in_ready  out  1  high only in IDLE
- in_data  in  N_IN*DW  flattened activations, element k at [k*DW +: DW]
- w_addr  out  $clog2(N_IN*N_OUT)  weight ROM address = j*N_IN + k
- w_data  in  DW  weight, valid one cycle after w_addr
- b_addr  out  $clog2(N_OUT)  bias ROM address = j
- b_data  in  DW  bias, valid one cycle after b_addr
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_idx  out  $clog2(N_OUT)  neuron index j of out_data
- out_data  out  DW  activated result
- layer_done  out  1  one-cycle pulse after the last neuron's handshake

## Operation
- FSM states: IDLE, MAC, ACT, OUT.
- **IDLE**
  - in_ready=1.
  - On in_valid: latch in_data into the vector register; clear j, k and acc; go to MAC.
  - in_data is ignored at all other times.
- **MAC**, N_IN+1 cycles, counter k=0..N_IN
  - While k<N_IN: drive w_addr=j*N_IN+k.
  - While k>=1: acc += low DW bits of signed(w_data)*signed(x[k-1]).
  - b_addr=j is held throughout MAC.
  - After k=N_IN, go to ACT.
- **ACT**, 1 cycle
  - sum = acc + b_data, 32-bit two's complement, wrap on overflow.
  - If sum[31]==0: out_data = zero-extended sum[FRAC+15:FRAC] (16 bits; bits 31:29 of sum are discarded). Otherwise out_data = 0.
  - Set out_idx=j and out_valid=1; go to OUT.
- **OUT**
  - Hold out_valid, out_data and out_idx stable until out_ready.
  - On handshake, if j<N_OUT-1: j++, clear k and acc, go to MAC.
  - On handshake, if j==N_OUT-1: pulse layer_done, go to IDLE.
- All arithmetic is signed and modulo 2^32: product low words and the accumulator both wrap silently.

## Timing
- Reset values: out_valid=0, out_data=0, out_idx=0, layer_done=0, w_addr=0, b_addr=0, state=IDLE. in_ready becomes 1 as soon as reset is released.
- Reset asserted mid-layer aborts the layer immediately. No partial out_valid is produced. The next vector starts at j=0.
- Latency: out_valid for neuron 0 rises N_IN+2 cycles after the accept edge (17 cycles with defaults).
- Per-neuron period with out_ready held high: N_IN+3 cycles. Full layer: N_OUT*(N_IN+3) cycles (576 with defaults).
- ROM read latency is exactly 1 cycle; w_addr and b_addr are registered.
- out_ready may be high before out_valid. The transfer completes on the first cycle where both are high.
- layer_done is asserted in the cycle the FSM is back in IDLE, so in_ready is high in that same cycle. A new vector may be accepted on that cycle.

## Structure
- Shared package nn_pkg holds:
  - DW and FRAC defaults
  - the state enum
  - a relu_q function mapping a 32-bit sum to the activated DW result, shared with the parallel node blocks
- Sub-module nn_mac_unit contains the signed multiplier, accumulator register, clear and enable. The scheduler owns the FSM, counters, vector register and ROM addressing.

## Test plan
- **Basic:** all x=8192, all weights=1, bias=451, out_ready=1.
  - Each neuron has sum=123331, so out_data=15.
  - out_idx steps 0..31 at 18-cycle spacing; one layer_done pulse.
- **Negative:** all weights=-1, bias=451.
  - sum=-122429, so out_data=0 for every neuron.
- **Wrap:** x0=0x00010000, w0=0x00010000, all other weights 0, bias=8192.
  - The product wraps to 0, so sum=8192 and out_data=1.
- **Truncation:** x=8192, w=8192 for all k, bias 0.
  - sum=0x3C000000, so out_data=57344.
- **Backpressure:** out_ready low for 5 cycles at neuron 3.
  - out_data and out_idx stay stable; w_addr does not advance; neuron 4 follows exactly N_IN+3 cycles after release.
- **Reset mid-MAC** at neuron 7, k=5:
  - Outputs return to reset values within the same cycle.
  - Next vector yields out_idx=0 first, with correct results.
  - in_data changed mid-layer has no effect.

Source files
------------

// File: rtl/layer_mac_scheduler_pkg.sv
// Shared definitions for the layer MAC scheduler: data format, FSM state
// encoding and the ReLU/Q13 output mapping used by every neuron engine.
package layer_mac_scheduler_pkg;

  localparam int DW        = 32;
  localparam int FRAC      = 13;
  localparam int N_IN_DEF  = 15;
  localparam int N_OUT_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_ACT  = 2'd2,
    S_OUT  = 2'd3
  } state_e;

  // Negative sums clamp to zero. Positive sums keep the 16 bits just above
  // the binary point, so integer bits 31:29 are deliberately dropped.
  function automatic logic [DW-1:0] relu_q(input logic [DW-1:0] sum);
    logic [DW-1:0] res;
    res = '0;
    if (!sum[DW-1]) begin
      res[15:0] = sum[FRAC+15:FRAC];
    end
    return res;
  endfunction

endpackage

// File: rtl/layer_mac_scheduler_if.sv
// Bundle of the vector input, ROM fetch and result handshake signals of the
// layer MAC scheduler. The scheduler uses the master view, its environment
// (vector source, weight/bias ROMs, result sink) uses the slave view.
interface layer_mac_scheduler_if #(
  parameter int N_IN  = layer_mac_scheduler_pkg::N_IN_DEF,
  parameter int N_OUT = layer_mac_scheduler_pkg::N_OUT_DEF
);
  import layer_mac_scheduler_pkg::*;

  localparam int WAW = $clog2(N_IN * N_OUT);
  localparam int BAW = $clog2(N_OUT);

  logic                 in_valid;
  logic                 in_ready;
  logic [N_IN*DW-1:0]   in_data;
  logic [WAW-1:0]       w_addr;
  logic [DW-1:0]        w_data;
  logic [BAW-1:0]       b_addr;
  logic [DW-1:0]        b_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [BAW-1:0]       out_idx;
  logic [DW-1:0]        out_data;
  logic                 layer_done;

  modport master (
    input  in_valid, in_data, w_data, b_data, out_ready,
    output in_ready, w_addr, b_addr, out_valid, out_idx, out_data, layer_done
  );

  modport slave (
    output in_valid, in_data, w_data, b_data, out_ready,
    input  in_ready, w_addr, b_addr, out_valid, out_idx, out_data, layer_done
  );

endinterface

// File: rtl/layer_mac_scheduler_mac.sv
// Shared multiply-accumulate unit: one signed product per enabled cycle,
// added into a 32-bit accumulator that wraps silently.
module layer_mac_scheduler_mac
  import layer_mac_scheduler_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          en_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] acc_o
);

  logic [DW-1:0] prod_lo;
  logic [DW-1:0] acc_q, acc_d;

  // Only the low word of the product is kept, so a DW-wide multiply is enough.
  assign prod_lo = $signed(a_i) * $signed(b_i);

  // Clear has priority so a new neuron always starts from zero.
  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + prod_lo;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/layer_mac_scheduler.sv
// Time-multiplexed fully connected layer: evaluates N_OUT neurons one after
// another on a single MAC unit, fetching weights and biases from 1-cycle
// synchronous ROMs and emitting one ReLU'd Q13 result per neuron.
module layer_mac_scheduler
  import layer_mac_scheduler_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int N_OUT = N_OUT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  layer_mac_scheduler_if.master bus
);

  localparam int WAW = $clog2(N_IN * N_OUT);
  localparam int BAW = $clog2(N_OUT);
  localparam int KW  = $clog2(N_IN + 1);

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [BAW-1:0]  j_q, j_d;
  logic [WAW-1:0]  w_addr_q, w_addr_d;
  logic            out_valid_q, out_valid_d;
  logic [BAW-1:0]  out_idx_q, out_idx_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic            layer_done_q, layer_done_d;
  logic [DW-1:0]   vec_q [N_IN];
  logic            vec_load;
  logic            mac_clear;
  logic            mac_en;
  logic [DW-1:0]   x_sel;
  logic [DW-1:0]   acc;

  // The weight arriving at step k was addressed at step k-1, so it pairs with x[k-1].
  always_comb begin
    x_sel = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (k_q == KW'(i + 1)) begin
        x_sel = vec_q[i];
      end
    end
  end

  // Next-state, counter, ROM address and result logic of the neuron sequencer.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    j_d          = j_q;
    w_addr_d     = w_addr_q;
    out_valid_d  = out_valid_q;
    out_idx_d    = out_idx_q;
    out_data_d   = out_data_q;
    layer_done_d = 1'b0;
    vec_load     = 1'b0;
    mac_clear    = 1'b0;
    mac_en       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          vec_load  = 1'b1;
          mac_clear = 1'b1;
          j_d       = '0;
          k_d       = '0;
          w_addr_d  = '0;
          state_d   = S_MAC;
        end
      end
      S_MAC: begin
        mac_en = (k_q != '0);
        if (k_q == KW'(N_IN)) begin
          state_d = S_ACT;
        end else begin
          k_d = k_q + KW'(1);
          if (k_q < KW'(N_IN - 1)) begin
            w_addr_d = w_addr_q + WAW'(1);
          end
        end
      end
      S_ACT: begin
        out_data_d  = relu_q(acc + bus.b_data);
        out_idx_d   = j_q;
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (j_q == BAW'(N_OUT - 1)) begin
            layer_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            j_d       = j_q + BAW'(1);
            k_d       = '0;
            mac_clear = 1'b1;
            w_addr_d  = w_addr_q + WAW'(1);
            state_d   = S_MAC;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and output registers; reset aborts any layer in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      j_q          <= '0;
      w_addr_q     <= '0;
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_data_q   <= '0;
      layer_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      j_q          <= j_d;
      w_addr_q     <= w_addr_d;
      out_valid_q  <= out_valid_d;
      out_idx_q    <= out_idx_d;
      out_data_q   <= out_data_d;
      layer_done_q <= layer_done_d;
    end
  end

  // Activation vector is captured only on accept and held for the whole layer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_IN; i++) begin
        vec_q[i] <= '0;
      end
    end else if (vec_load) begin
      for (int i = 0; i < N_IN; i++) begin
        vec_q[i] <= bus.in_data[i*DW +: DW];
      end
    end
  end

  layer_mac_scheduler_mac u_mac (
    .clk     (clk),
    .reset   (reset),
    .clear_i (mac_clear),
    .en_i    (mac_en),
    .a_i     (bus.w_data),
    .b_i     (x_sel),
    .acc_o   (acc)
  );

  assign bus.in_ready   = (state_q == S_IDLE) && !reset;
  assign bus.w_addr     = w_addr_q;
  assign bus.b_addr     = j_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_idx    = out_idx_q;
  assign bus.out_data   = out_data_q;
  assign bus.layer_done = layer_done_q;

endmodule

// File: tb/tb_layer_mac_scheduler.sv
// Scoreboard bench for layer_mac_scheduler: stimulus pushes expected neuron
// results computed by a plain-arithmetic reference; a monitor pops and
// compares on each result handshake and also checks timing and stability.
module tb_layer_mac_scheduler;
  import layer_mac_scheduler_pkg::*;

  localparam int N_IN    = 15;
  localparam int N_OUT   = 32;
  localparam int LAT     = N_IN + 2;
  localparam int TIMEOUT = 4000;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  layer_mac_scheduler_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

  layer_mac_scheduler #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] wRom [N_IN*N_OUT];
  logic [DW-1:0] bRom [N_OUT];
  logic [DW-1:0] curX [N_IN];

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   refEdge    = 0;
  int   doneEdge   = -1;
  int   hsInLayer  = 0;
  int   holdLow    = 0;
  bit   randomReady = 1'b0;

  bit          prevValid = 1'b0;
  bit          prevReady = 1'b0;
  logic [31:0] prevData;
  logic [31:0] prevIdx;
  logic [31:0] prevW;

  always #5 clk = ~clk;

  // Posedge counter used to measure latencies in cycles.
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ROMs with one cycle of read latency.
  always @(posedge clk) begin
    bus.w_data <= wRom[bus.w_addr];
    bus.b_data <= bRom[bus.b_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h required 0x%08h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic timeoutFail(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: bound of %0d cycles expired", name, TIMEOUT);
  endtask

  // Reference neuron: signed dot product and bias in wrapping 32-bit int
  // arithmetic, then clamp negatives and keep 16 bits of the Q13 integer part.
  function automatic logic [31:0] refNeuron(input int j);
    int acc;
    acc = 0;
    for (int k = 0; k < N_IN; k++) begin
      acc += int'(wRom[j*N_IN + k]) * int'(curX[k]);
    end
    acc += int'(bRom[j]);
    if (acc < 0) return 32'd0;
    return 32'((acc / 8192) % 65536);
  endfunction

  function automatic logic [31:0] smallSigned(input int mag);
    return 32'(int'($urandom_range(0, 2*mag)) - mag);
  endfunction

  task automatic loadPattern(input int mode);
    for (int k = 0; k < N_IN; k++) begin
      case (mode)
        0, 1, 3: curX[k] = 32'd8192;
        2:       curX[k] = (k == 0) ? 32'h0001_0000 : 32'd0;
        default: curX[k] = smallSigned(16384);
      endcase
    end
    for (int a = 0; a < N_IN*N_OUT; a++) begin
      case (mode)
        0:       wRom[a] = 32'd1;
        1:       wRom[a] = 32'hFFFF_FFFF;
        2:       wRom[a] = ((a % N_IN) == 0) ? 32'h0001_0000 : 32'd0;
        3:       wRom[a] = 32'd8192;
        default: wRom[a] = ($urandom_range(0, 7) == 0) ? $urandom() : smallSigned(16384);
      endcase
    end
    for (int j = 0; j < N_OUT; j++) begin
      case (mode)
        0, 1:    bRom[j] = 32'd451;
        2:       bRom[j] = 32'd8192;
        3:       bRom[j] = 32'd0;
        default: bRom[j] = smallSigned(1 << 20);
      endcase
    end
  endtask

  task automatic applyStimulus();
    int waited;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      timeoutFail("in_ready_wait");
      return;
    end
    for (int k = 0; k < N_IN; k++) bus.in_data[k*DW +: DW] = curX[k];
    bus.in_valid = 1'b1;
    for (int j = 0; j < N_OUT; j++) expQ.push_back('{idx: j, data: refNeuron(j)});
    refEdge   = cyc + 1;
    hsInLayer = 0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int k = 0; k < N_IN; k++) bus.in_data[k*DW +: DW] = $urandom();
  endtask

  task automatic waitLayer();
    int waited;
    waited = 0;
    while (expQ.size() != 0 && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    if (expQ.size() != 0) begin
      timeoutFail("layer_complete");
      expQ.delete();
    end
  endtask

  task automatic waitHandshakes(input int n);
    int waited;
    waited = 0;
    while (hsInLayer < n && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    if (hsInLayer < n) timeoutFail("handshake_wait");
  endtask

  task automatic checkResetOutputs(input logic readyReq);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_data", bus.out_data, 32'd0);
    checkOutput("rst_out_idx", 32'(bus.out_idx), 32'd0);
    checkOutput("rst_layer_done", 32'(bus.layer_done), 32'd0);
    checkOutput("rst_w_addr", 32'(bus.w_addr), 32'd0);
    checkOutput("rst_b_addr", 32'(bus.b_addr), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'(readyReq));
  endtask

  // Result sink: out_ready is high unless backpressure or random mode is active.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (holdLow > 0) begin
        bus.out_ready = 1'b0;
        holdLow--;
      end else begin
        bus.out_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Monitor: samples just after the falling edge, i.e. the values the next
  // rising edge will see.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        if (bus.layer_done || cyc == doneEdge)
          checkOutput("layer_done", 32'(bus.layer_done), 32'(cyc == doneEdge));
        if (bus.out_valid && !prevValid)
          checkOutput("valid_latency", 32'(cyc - refEdge), 32'(LAT));
        if (prevValid && !prevReady) begin
          checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
          checkOutput("hold_data", bus.out_data, prevData);
          checkOutput("hold_idx", 32'(bus.out_idx), prevIdx);
          checkOutput("hold_w_addr", 32'(bus.w_addr), prevW);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_result", 32'(bus.out_idx), 32'hFFFF_FFFF);
          end else begin
            e = expQ.pop_front();
            checkOutput("out_idx", 32'(bus.out_idx), 32'(e.idx));
            checkOutput("out_data", bus.out_data, e.data);
            hsInLayer++;
            refEdge = cyc + 1;
            if (e.idx == N_OUT - 1) doneEdge = cyc + 1;
          end
        end
      end
      prevValid = bus.out_valid && !reset;
      prevReady = bus.out_ready;
      prevData  = bus.out_data;
      prevIdx   = 32'(bus.out_idx);
      prevW     = 32'(bus.w_addr);
    end
  end

  // Hard stop in case the DUT wedges in a way the bounded waits miss.
  initial begin
    #2000000;
    mismatched++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] watchdog");
  end

  // Directed patterns, backpressure, mid-layer reset and random layers.
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    reset        = 1'b1;
    for (int j = 0; j < N_OUT; j++) bRom[j] = '0;
    for (int a = 0; a < N_IN*N_OUT; a++) wRom[a] = '0;
    repeat (2) @(negedge clk);
    #1;
    checkResetOutputs(1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("in_ready_after_reset", 32'(bus.in_ready), 32'd1);

    for (int mode = 0; mode < 4; mode++) begin
      $display("[TB] directed pattern %0d", mode);
      loadPattern(mode);
      applyStimulus();
      waitLayer();
    end

    $display("[TB] backpressure at neuron 3");
    loadPattern(4);
    applyStimulus();
    waitHandshakes(3);
    holdLow = 22;
    waitLayer();

    $display("[TB] reset during neuron 7");
    loadPattern(4);
    applyStimulus();
    waitHandshakes(7);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    expQ.delete();
    doneEdge = -1;
    #1;
    checkResetOutputs(1'b0);
    @(negedge clk);
    reset = 1'b0;
    loadPattern(4);
    applyStimulus();
    waitLayer();

    $display("[TB] random layers with random out_ready");
    randomReady = 1'b1;
    for (int n = 0; n < 2; n++) begin
      loadPattern(4);
      applyStimulus();
      waitLayer();
    end
    randomReady = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("final_idle", 32'(bus.in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
